// File: rtl/apb_led_matrix.sv
// APB-driven 4x4 LED matrix scanner: active-low row strobes, blanking between rows, frame-done interrupt.
// Optional per-row PWM dimming via CTRL.DUTY when LED_MATRIX_PWM_EN is defined.
module apb_led_matrix #(
  parameter int unsigned ROW_CYCLES   = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic [3:0]  row_n,
  output logic [3:0]  col,
  output logic        FrameINT
);

  localparam int unsigned    CW        = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  typedef enum logic [1:0] {
    A_PATTERN = 2'd0,
    A_CTRL    = 2'd1,
    A_STATUS  = 2'd2,
    A_NONE    = 2'd3
  } addr_e;

  addr_e addr;
  logic  wr_en, wr_pattern, wr_ctrl, wr_status;
  logic  wrap;

  logic [15:0]   pattern_q, pattern_d;
  logic          en_q, en_d;
  logic          inten_q, inten_d;
  logic          flag_q, flag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    r_q, r_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    row_n_q, row_n_d;
  logic [3:0]    col_q, col_d;
`ifdef LED_MATRIX_PWM_EN
  logic [3:0]    duty_q, duty_d;
  logic [3:0]    p_q, p_d;
`endif

  logic unused_bits;
  assign unused_bits = ^{PWDATA[31:16], PADDR[1:0]};

  assign addr       = addr_e'(PADDR[3:2]);
  assign wr_en      = PSEL & PENABLE & PWRITE;
  assign wr_pattern = wr_en && (addr == A_PATTERN);
  assign wr_ctrl    = wr_en && (addr == A_CTRL);
  assign wr_status  = wr_en && (addr == A_STATUS);

  always_comb begin
    pattern_d = pattern_q;
    en_d      = en_q;
    inten_d   = inten_q;
    flag_d    = flag_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    shadow_d  = shadow_q;
    wrap      = 1'b0;
`ifdef LED_MATRIX_PWM_EN
    duty_d    = duty_q;
`endif

    if (wr_pattern) pattern_d = PWDATA[15:0];
    if (wr_ctrl) begin
      en_d    = PWDATA[0];
      inten_d = PWDATA[1];
`ifdef LED_MATRIX_PWM_EN
      duty_d  = PWDATA[7:4];
`endif
    end

    // An EN toggle restarts the scan; on enable the frame latches the current pattern.
    if (wr_ctrl && (PWDATA[0] != en_q)) begin
      cnt_d = '0;
      r_d   = '0;
      if (PWDATA[0]) shadow_d = pattern_d;
    end else if (!en_q) begin
      cnt_d    = '0;
      r_d      = '0;
      shadow_d = pattern_d;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      r_d   = r_q + 1'b1;
      if (r_q == 2'd3) begin
        wrap     = 1'b1;
        shadow_d = pattern_d;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (wr_status && PWDATA[0]) flag_d = 1'b0;
    if (wrap)                   flag_d = 1'b1;
  end

  // Drive values are derived from the current counter state and registered, so pins lag cnt/r by one cycle.
  always_comb begin
    row_n_d = '1;
    col_d   = '0;
`ifdef LED_MATRIX_PWM_EN
    p_d     = '0;
`endif
    if (en_q && (cnt_q >= CNT_BLANK)) begin
      row_n_d = ~(4'b0001 << r_q);
      col_d   = shadow_q[{r_q, 2'b00} +: 4];
`ifdef LED_MATRIX_PWM_EN
      if (p_q > duty_q) col_d = '0;
      p_d = p_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= '0;
      en_q      <= 1'b0;
      inten_q   <= 1'b0;
      flag_q    <= 1'b0;
      cnt_q     <= '0;
      r_q       <= '0;
      shadow_q  <= '0;
      row_n_q   <= '1;
      col_q     <= '0;
`ifdef LED_MATRIX_PWM_EN
      duty_q    <= '0;
      p_q       <= '0;
`endif
    end else begin
      pattern_q <= pattern_d;
      en_q      <= en_d;
      inten_q   <= inten_d;
      flag_q    <= flag_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      shadow_q  <= shadow_d;
      row_n_q   <= row_n_d;
      col_q     <= col_d;
`ifdef LED_MATRIX_PWM_EN
      duty_q    <= duty_d;
      p_q       <= p_d;
`endif
    end
  end

  always_comb begin
    PRDATA = '0;
    case (addr)
      A_PATTERN: PRDATA[15:0] = pattern_q;
      A_CTRL: begin
        PRDATA[0] = en_q;
        PRDATA[1] = inten_q;
`ifdef LED_MATRIX_PWM_EN
        PRDATA[7:4] = duty_q;
`endif
      end
      A_STATUS: begin
        PRDATA[0]   = flag_q;
        PRDATA[3:2] = r_q;
      end
      default: PRDATA = '0;
    endcase
  end

  assign PREADY   = 1'b1;
  assign row_n    = row_n_q;
  assign col      = col_q;
  assign FrameINT = flag_q & inten_q;

endmodule
